// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low abcdefg patterns and code constants,
// used by both the display driver and the scan receiver.
package sevenseg_pkg;

  localparam logic [3:0] CODE_DASH    = 4'hA;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  localparam logic [6:0] SEG_DASH = 7'b1111110;

  // Element n is the active-low pattern for digit n (bit 6 = a ... bit 0 = g)
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0000100,
    7'b0000000,
    7'b0001111,
    7'b0100000,
    7'b0100100,
    7'b1001100,
    7'b0000110,
    7'b0010010,
    7'b1001111,
    7'b0000001
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } scan_state_t;

  function automatic logic [6:0] twoDigitValue(input logic [3:0] tens, input logic [3:0] ones);
    if (tens > 4'd9 || ones > 4'd9) begin
      return 7'h7F;
    end
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational lookup from an active-low segment pattern to a digit code
// (0..9, CODE_DASH, or CODE_INVALID for anything unrecognised).
module seg7_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code
);

  always_comb begin
    o_code = CODE_INVALID;
    if (i_seg == SEG_DASH) begin
      o_code = CODE_DASH;
    end
    for (int i = 0; i < 10; i++) begin
      if (i_seg == SEG_DIGIT[i]) begin
        o_code = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_rx.sv
// Recovers digits from a multiplexed seven-segment bus by waiting for each strobe to settle.
// Optional saturating error counter: define SCAN_RX_ERRCNT_EN.
module sevenseg_scan_rx
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int NUM_DIGITS    = 2
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic [7:0]  AN_IN,
  input  logic [6:0]  SEG_IN,
  output logic [31:0] DIGITS,
  output logic [6:0]  VALUE,
  output logic        FRAME_VALID,
  output logic        SEG_ERR,
  output logic [7:0]  ERR_COUNT
);

  localparam logic [7:0] FULL_MASK = 8'((1 << NUM_DIGITS) - 1);

  scan_state_t r_state;
  scan_state_t w_nextState;

  logic [14:0] r_prev;
  logic [7:0]  r_cnt;
  logic [7:0]  r_mask;
  logic [31:0] r_digits;
  logic [6:0]  r_value;
  logic        r_frameValid;
  logic        r_segErr;

  logic [14:0] w_sample;
  logic        w_changed;
  logic        w_legal;
  logic        w_capture;
  logic        w_restart;
  logic [2:0]  w_idx;
  logic [3:0]  w_code;
  logic [31:0] w_digitsNext;
  logic [7:0]  w_maskNext;

  assign w_sample  = {AN_IN, SEG_IN};
  assign w_changed = (w_sample != r_prev);

  // A sample is only usable when exactly one in-range anode is driven low
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!AN_IN[i]) begin
        w_idx = 3'(i);
      end
    end
    w_legal = ($countones(~AN_IN) == 1) && (int'(w_idx) < NUM_DIGITS);
  end

  seg7_decode u_decode (
    .i_seg  (SEG_IN),
    .o_code (w_code)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_legal) begin
          w_nextState = SETTLE;
        end
      end
      SETTLE: begin
        if (w_changed) begin
          w_nextState = w_legal ? SETTLE : IDLE;
        end else if (r_cnt == 8'(STABLE_CYCLES - 1)) begin
          w_nextState = HELD;
        end
      end
      HELD: begin
        if (w_changed) begin
          w_nextState = w_legal ? SETTLE : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == SETTLE) && !w_changed && (r_cnt == 8'(STABLE_CYCLES - 1));
    w_restart = w_legal && ((r_state == IDLE) || w_changed);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_restart) begin
      r_cnt <= 8'd1;
    end else if (r_state == SETTLE && !w_changed) begin
      r_cnt <= r_cnt + 8'd1;
    end else if (w_nextState == IDLE) begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    w_digitsNext = r_digits;
    w_digitsNext[{w_idx, 2'b00} +: 4] = w_code;
    w_maskNext = r_mask | (8'b1 << w_idx);
  end

  // The frame result is registered alongside the capture so DIGITS and VALUE agree
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_prev       <= '1;
      r_mask       <= '0;
      r_digits     <= 32'hFFFF_FFFF;
      r_value      <= 7'h7F;
      r_frameValid <= 1'b0;
      r_segErr     <= 1'b0;
    end else begin
      r_prev       <= w_sample;
      r_frameValid <= 1'b0;
      if (w_capture) begin
        r_digits <= w_digitsNext;
        if (w_code == CODE_INVALID) begin
          r_segErr <= 1'b1;
        end
        if ((w_maskNext & FULL_MASK) == FULL_MASK) begin
          r_frameValid <= 1'b1;
          r_value      <= twoDigitValue((NUM_DIGITS > 1) ? w_digitsNext[7:4] : 4'h0,
                                        w_digitsNext[3:0]);
          r_mask       <= '0;
        end else begin
          r_mask <= w_maskNext;
        end
      end
    end
  end

`ifdef SCAN_RX_ERRCNT_EN
  logic [7:0] r_errCount;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_errCount <= '0;
    end else if (w_capture && w_code == CODE_INVALID && r_errCount != 8'hFF) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end

  assign ERR_COUNT = r_errCount;
`else
  assign ERR_COUNT = 8'h00;
`endif

  assign DIGITS      = r_digits;
  assign VALUE       = r_value;
  assign FRAME_VALID = r_frameValid;
  assign SEG_ERR     = r_segErr;

endmodule

// File: tb/tb_sevenseg_scan_rx.sv
// Bench for sevenseg_scan_rx: directed scenarios with literal expectations plus
// randomized scanning checked every cycle against a run-length reference model.
module tb_sevenseg_scan_rx;

  localparam int STABLE = 16;
  localparam int ND     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] DIGITS;
  logic [6:0]  VALUE;
  logic        FRAME_VALID;
  logic        SEG_ERR;
  logic [7:0]  ERR_COUNT;

  int numCompared   = 0;
  int numMismatched = 0;
  int fvCount       = 0;

  logic [3:0]  mDigit [8] = '{default: 4'hF};
  logic [6:0]  mValue  = 7'h7F;
  logic        mFv     = 1'b0;
  logic        mErr    = 1'b0;
  logic [7:0]  mErrCnt = 8'h00;
  logic [7:0]  mSeen   = 8'h00;
  logic [14:0] mLast   = '1;
  int          mRun    = 0;

  logic [6:0] patTable [11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b1111110};

  always #5 clk = ~clk;

  sevenseg_scan_rx #(
    .STABLE_CYCLES (STABLE),
    .NUM_DIGITS    (ND)
  ) dut (
    .CLK100MHZ   (clk),
    .RST         (rst),
    .AN_IN       (an),
    .SEG_IN      (seg),
    .DIGITS      (DIGITS),
    .VALUE       (VALUE),
    .FRAME_VALID (FRAME_VALID),
    .SEG_ERR     (SEG_ERR),
    .ERR_COUNT   (ERR_COUNT)
  );

  function automatic logic [3:0] refDecode(input logic [6:0] p);
    case (p)
      7'b0000001: return 4'd0;
      7'b1001111: return 4'd1;
      7'b0010010: return 4'd2;
      7'b0000110: return 4'd3;
      7'b1001100: return 4'd4;
      7'b0100100: return 4'd5;
      7'b0100000: return 4'd6;
      7'b0001111: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0000100: return 4'd9;
      7'b1111110: return 4'hA;
      default:    return 4'hF;
    endcase
  endfunction

  // A digit is captured on the sample where its run of identical legal samples reaches STABLE
  always @(posedge clk) begin : refModel
    int zeros;
    int idx;
    int d0;
    int d1;
    bit allSeen;
    logic [3:0] code;
    if (rst) begin
      for (int i = 0; i < 8; i++) mDigit[i] = 4'hF;
      mValue  = 7'h7F;
      mFv     = 1'b0;
      mErr    = 1'b0;
      mErrCnt = 8'h00;
      mSeen   = 8'h00;
      mRun    = 0;
      mLast   = '1;
    end else begin
      mFv   = 1'b0;
      zeros = 0;
      idx   = 0;
      for (int i = 0; i < 8; i++) begin
        if (!an[i]) begin
          zeros++;
          idx = i;
        end
      end
      if (zeros != 1 || idx >= ND) mRun = 0;
      else if ({an, seg} == mLast && mRun > 0) mRun = (mRun < 1000) ? mRun + 1 : mRun;
      else mRun = 1;
      mLast = {an, seg};
      if (mRun == STABLE) begin
        code = refDecode(seg);
        mDigit[idx] = code;
        mSeen[idx]  = 1'b1;
        if (code == 4'hF) begin
          mErr = 1'b1;
`ifdef SCAN_RX_ERRCNT_EN
          if (mErrCnt != 8'hFF) mErrCnt = mErrCnt + 8'd1;
`endif
        end
        allSeen = 1'b1;
        for (int i = 0; i < ND; i++) if (!mSeen[i]) allSeen = 1'b0;
        if (allSeen) begin
          d0 = int'(mDigit[0]);
          d1 = (ND > 1) ? int'(mDigit[1]) : 0;
          mValue = (d0 <= 9 && d1 <= 9) ? 7'(d1 * 10 + d0) : 7'h7F;
          mFv    = 1'b1;
          mSeen  = 8'h00;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin : compareProc
    checkOutput("DIGITS", DIGITS, {mDigit[7], mDigit[6], mDigit[5], mDigit[4],
                                   mDigit[3], mDigit[2], mDigit[1], mDigit[0]});
    checkOutput("VALUE", 32'(VALUE), 32'(mValue));
    checkOutput("FRAME_VALID", 32'(FRAME_VALID), 32'(mFv));
    checkOutput("SEG_ERR", 32'(SEG_ERR), 32'(mErr));
    checkOutput("ERR_COUNT", 32'(ERR_COUNT), 32'(mErrCnt));
    if (FRAME_VALID === 1'b1) fvCount++;
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [6:0] s, input int cycles);
    an  = a;
    seg = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    an  = 8'hFF;
    seg = 7'h7F;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_DIGITS"}, DIGITS, 32'hFFFF_FFFF);
    checkOutput({tag, "_VALUE"}, 32'(VALUE), 32'h7F);
    checkOutput({tag, "_FV"}, 32'(FRAME_VALID), 32'h0);
    checkOutput({tag, "_SEGERR"}, 32'(SEG_ERR), 32'h0);
    checkOutput({tag, "_ERRCNT"}, 32'(ERR_COUNT), 32'h0);
  endtask

  initial begin : mainSeq
    int fvBase;
    int pick;
    logic [7:0] a;
    logic [6:0] s;
    int hold;

    rst = 1'b1;
    an  = 8'hFF;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;

    $display("[TB] two-digit frame 25");
    fvBase = fvCount;
    applyStimulus(8'hFE, 7'b0100100, STABLE);
    checkOutput("d0_captured", 32'(DIGITS[3:0]), 32'h5);
    applyStimulus(8'hFD, 7'b0010010, STABLE);
    applyStimulus(8'hFF, 7'h7F, 2);
    checkOutput("f25_pulses", 32'(fvCount - fvBase), 32'd1);
    checkOutput("f25_value", 32'(VALUE), 32'd25);
    checkOutput("f25_digits", 32'(DIGITS[7:0]), 32'h25);

    $display("[TB] one cycle short of stable");
    applyReset(2);
    applyStimulus(8'hFE, 7'b0000001, STABLE - 1);
    applyStimulus(8'hFF, 7'h7F, 5);
    checkOutput("short_digits", DIGITS, 32'hFFFF_FFFF);

    $display("[TB] dash on digit 1");
    fvBase = fvCount;
    applyStimulus(8'hFD, 7'b1111110, STABLE);
    applyStimulus(8'hFE, 7'b0000110, STABLE);
    applyStimulus(8'hFF, 7'h7F, 2);
    checkOutput("dash_pulses", 32'(fvCount - fvBase), 32'd1);
    checkOutput("dash_nibbles", 32'(DIGITS[7:0]), 32'hA3);
    checkOutput("dash_value", 32'(VALUE), 32'h7F);

    $display("[TB] undecodable pattern x3");
    applyReset(2);
    fvBase = fvCount;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'hFE, 7'b1010101, STABLE);
      applyStimulus(8'hFF, 7'h7F, 1);
    end
    checkOutput("err_flag", 32'(SEG_ERR), 32'h1);
`ifdef SCAN_RX_ERRCNT_EN
    checkOutput("err_count", 32'(ERR_COUNT), 32'd3);
`else
    checkOutput("err_count", 32'(ERR_COUNT), 32'd0);
`endif
    checkOutput("err_nibble", 32'(DIGITS[3:0]), 32'hF);
    checkOutput("err_no_frame", 32'(fvCount - fvBase), 32'd0);

    $display("[TB] illegal anode patterns");
    applyReset(2);
    fvBase = fvCount;
    applyStimulus(8'hFC, 7'b0000001, 100);
    applyStimulus(8'hFF, 7'b0000001, 100);
    checkOutput("illegal_digits", DIGITS, 32'hFFFF_FFFF);
    checkOutput("illegal_no_frame", 32'(fvCount - fvBase), 32'd0);

    $display("[TB] reset discards partial frame");
    applyReset(2);
    applyStimulus(8'hFD, 7'b0000000, STABLE);
    checkOutput("partial_d1", 32'(DIGITS[7:4]), 32'h8);
    applyReset(1);
    checkResetValues("midreset");
    fvBase = fvCount;
    applyStimulus(8'hFE, 7'b0000001, STABLE);
    applyStimulus(8'hFF, 7'h7F, 2);
    checkOutput("after_reset_no_frame", 32'(fvCount - fvBase), 32'd0);
    checkOutput("after_reset_digits", DIGITS, 32'hFFFF_FFF0);

    $display("[TB] randomized scanning");
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        applyReset(int'($urandom_range(1, 2)));
      end else begin
        pick = int'($urandom_range(0, 9));
        case (pick)
          0, 1, 2, 3: a = 8'hFE;
          4, 5, 6:    a = 8'hFD;
          7:          a = 8'hFF;
          8:          a = 8'hFB;
          default:    a = 8'($urandom);
        endcase
        pick = int'($urandom_range(0, 13));
        s = (pick < 11) ? patTable[pick] : 7'($urandom);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                           : int'($urandom_range(14, 24));
        applyStimulus(a, s, hold);
      end
    end
    applyStimulus(8'hFF, 7'h7F, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
